// File: rtl/theta_pkg.sv
// theta_pkg
// Shared definitions for the theta stream engine:
//   - default matrix side and slice depth
//   - the two-state controller enum
//   - index helper mapping lane (x,y) onto a flat slice bit
//   - modular neighbour helpers for the column index
package theta_pkg;

   localparam int DEFAULT_N     = 5;
   localparam int DEFAULT_DEPTH = 64;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } theta_state_e;

   // Flat bit position of lane (x,y) inside an n*n slice.
   function automatic int idx(input int x, input int y, input int n);
      return n * y + x;
   endfunction

   // Left neighbour column, wrapping 0 back to n-1.
   function automatic int xm1(input int x, input int n);
      return (x == 0) ? n - 1 : x - 1;
   endfunction

   // Right neighbour column, wrapping n-1 back to 0.
   function automatic int xp1(input int x, input int n);
      return (x == n - 1) ? 0 : x + 1;
   endfunction

endpackage

// File: rtl/theta_stream_engine_parity.sv
// slice_col_parity
// Purely combinational column parity of one N*N slice.
// Ports:
//   sliceData  in   N*N  slice, bit index = N*y + x
//   parity     out  N    parity[x] = XOR over y of lane (x,y)
module slice_col_parity
   import theta_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic [N*N-1:0] sliceData,
   output logic [N-1:0]   parity
);

   logic [N-1:0][N-1:0] colBits;

   // Regroup the flat slice so that each row of colBits holds one column,
   // then reduce each column to a single parity bit.
   for (genvar gx = 0; gx < N; gx++) begin : gCol
      for (genvar gy = 0; gy < N; gy++) begin : gRow
         localparam int B = idx(gx, gy, N);
         assign colBits[gx][gy] = sliceData[B];
      end
      assign parity[gx] = ^colBits[gx];
   end

endmodule

// File: rtl/theta_stream_engine.sv
// theta_stream_engine
// Buffers one full N x N x DEPTH state a slice at a time, computing column
// parities on the way in, then streams out either theta-mixed slices or the
// raw per-slice column parities.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input slice handshake
//   in_data   [N*N]     input slice, bit index = N*y + x
//   mode                0 = theta apply, 1 = parity only (taken with slice 0)
//   out_valid/out_ready output slice handshake
//   out_data  [N*N]     result slice, zero while out_valid is low
//   out_last            marks slice DEPTH-1 of the output stream
//   busy                a state is partially loaded or being emitted
module theta_stream_engine
   import theta_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*N-1:0] in_data,
   input  logic           mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*N-1:0] out_data,
   output logic           out_last,
   output logic           busy
);

   localparam int W  = N * N;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   theta_state_e  stateQ;
   theta_state_e  stateD;
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] zPrev;
   logic          modeQ;
   logic          acceptIn;
   logic          outFire;
   logic [N-1:0]  colParity;
   logic [W-1:0]  sliceBuf  [DEPTH];
   logic [N-1:0]  parityBuf [DEPTH];
   logic [W-1:0]  curSlice;
   logic [N-1:0]  curPar;
   logic [N-1:0]  prevPar;
   logic [W-1:0]  thetaSlice;

   slice_col_parity #(.N(N)) uColParity (
      .sliceData (in_data),
      .parity    (colParity)
   );

   assign in_ready  = (stateQ == LOAD);
   assign out_valid = (stateQ == EMIT);
   assign acceptIn  = in_valid && in_ready;
   assign outFire   = out_valid && out_ready;
   assign out_last  = out_valid && (rdPtr == LAST_PTR);
   assign busy      = (stateQ == EMIT) || (wrPtr != '0);

   // State register. Reset drops straight back to LOAD so any partly loaded
   // or partly emitted state is abandoned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= LOAD;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic: LOAD finishes on the last slice accepted, EMIT
   // finishes on the last slice handed downstream. The two never overlap,
   // so the next load can only start the cycle after EMIT ends.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         LOAD: begin
            if (acceptIn && (wrPtr == LAST_PTR)) begin
               stateD = EMIT;
            end
         end
         EMIT: begin
            if (outFire && (rdPtr == LAST_PTR)) begin
               stateD = LOAD;
            end
         end
         default: begin
            stateD = LOAD;
         end
      endcase
   end

   // Write/read pointers and the mode latch. Mode is only captured with
   // slice 0 so that toggling it mid-state cannot change the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         modeQ <= 1'b0;
      end else begin
         if (acceptIn) begin
            wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PW'(1);
            if (wrPtr == '0) begin
               modeQ <= mode;
            end
         end
         if (outFire) begin
            rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PW'(1);
         end
      end
   end

   // Slice and parity storage. Contents are meaningless until a full state
   // has been loaded, so there is no reset on these arrays.
   always_ff @(posedge clk) begin
      if (acceptIn) begin
         sliceBuf[wrPtr]  <= in_data;
         parityBuf[wrPtr] <= colParity;
      end
   end

   // Fetch the current slice, its parity and the parity of the previous
   // slice (wrapping slice 0 back to DEPTH-1; with DEPTH=1 that is itself).
   always_comb begin
      zPrev    = (rdPtr == '0) ? LAST_PTR : rdPtr - PW'(1);
      curSlice = sliceBuf[rdPtr];
      curPar   = parityBuf[rdPtr];
      prevPar  = parityBuf[zPrev];
   end

   // Theta mix: each lane picks up the parity of the column to its left in
   // the same slice and of the column to its right in the previous slice.
   for (genvar gx = 0; gx < N; gx++) begin : gThetaX
      for (genvar gy = 0; gy < N; gy++) begin : gThetaY
         localparam int B = idx(gx, gy, N);
         localparam int L = xm1(gx, N);
         localparam int R = xp1(gx, N);
         assign thetaSlice[B] = curSlice[B] ^ curPar[L] ^ prevPar[R];
      end
   end

   // Output mux: zero whenever nothing is being emitted, otherwise the
   // theta-mixed slice or the bare column parity in the low N bits.
   always_comb begin
      out_data = '0;
      if (stateQ == EMIT) begin
         if (modeQ) begin
            out_data[N-1:0] = curPar;
         end else begin
            out_data = thetaSlice;
         end
      end
   end

endmodule

// File: tb/tb_theta_stream_engine.sv
// tb_theta_stream_engine
// Directed bench for theta_stream_engine at N=5, DEPTH=4. Inputs are driven
// and outputs sampled on the falling clock edge, so every handshake lands on
// the following rising edge.
module tb_theta_stream_engine;

   localparam int N     = 5;
   localparam int DEPTH = 4;
   localparam int W     = N * N;

   logic         clk;
   logic         rst_n;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] inData;
   logic         modeIn;
   logic         outValid;
   logic         outReady;
   logic [W-1:0] outData;
   logic         outLast;
   logic         busy;

   int vectorCount;
   int missCount;

   logic [3:0][W-1:0] refIn;
   logic [3:0][W-1:0] refOut;
   logic [3:0][W-1:0] zeroSlices;
   logic [3:0][W-1:0] wrapIn;
   logic [3:0][W-1:0] wrapOut;
   logic [3:0][W-1:0] parIn;
   logic [3:0][W-1:0] parOut;

   theta_stream_engine #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .mode      (modeIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_data  (outData),
      .out_last  (outLast),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Load four slices. The requested mode goes with slice 0 only; later
   // slices carry the opposite mode, which the engine must ignore.
   task automatic applyStimulus(input logic m, input logic [3:0][W-1:0] slices,
                                input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         inValid = 1'b1;
         inData  = slices[i];
         modeIn  = (i == 0) ? m : ~m;
         checkOutput($sformatf("%s in_ready s%0d", tag, i), {31'd0, inReady}, 32'd1);
         if (i > 0) begin
            checkOutput($sformatf("%s busy s%0d", tag, i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("%s out_valid s%0d", tag, i), {31'd0, outValid}, 32'd0);
         end
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inData  = '0;
   endtask

   // Take outputs fromIdx..toIdx with out_ready high, checking each slice.
   task automatic collectOutputs(input logic [3:0][W-1:0] expData, input string tag,
                                 input int fromIdx, input int toIdx);
      for (int j = fromIdx; j <= toIdx; j++) begin
         @(negedge clk);
         outReady = 1'b1;
         checkOutput($sformatf("%s out_valid o%0d", tag, j), {31'd0, outValid}, 32'd1);
         checkOutput($sformatf("%s out_data o%0d", tag, j), {7'd0, outData}, {7'd0, expData[j]});
         checkOutput($sformatf("%s out_last o%0d", tag, j), {31'd0, outLast},
                     (j == DEPTH - 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("%s in_ready o%0d", tag, j), {31'd0, inReady}, 32'd0);
      end
   endtask

   // Idle check once a state has fully drained.
   task automatic checkIdle(input string tag);
      @(negedge clk);
      checkOutput({tag, " idle in_ready"}, {31'd0, inReady}, 32'd1);
      checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " idle out_valid"}, {31'd0, outValid}, 32'd0);
      checkOutput({tag, " idle out_data"}, {7'd0, outData}, 32'd0);
   endtask

   // Main sequence.
   initial begin
      vectorCount = 0;
      missCount   = 0;
      rst_n       = 1'b0;
      inValid     = 1'b0;
      inData      = '0;
      modeIn      = 1'b0;
      outReady    = 1'b1;

      refIn      = {25'h0000000, 25'h0000000, 25'h0000000, 25'h0000001};
      refOut     = {25'h0000000, 25'h0000000, 25'h1084210, 25'h0210843};
      zeroSlices = '0;
      wrapIn     = {25'h0000001, 25'h0000000, 25'h0000000, 25'h0000000};
      wrapOut    = {25'h0210843, 25'h0000000, 25'h0000000, 25'h1084210};
      parIn      = {25'h0000000, 25'h0000000, 25'h0000003, 25'h0000021};
      parOut     = {25'h0000000, 25'h0000000, 25'h0000003, 25'h0000000};

      #1;
      checkOutput("reset in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset out_last", {31'd0, outLast}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset out_data", {7'd0, outData}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] all-zero state");
      applyStimulus(1'b0, zeroSlices, "zero");
      collectOutputs(zeroSlices, "zero", 0, 3);
      checkIdle("zero");

      $display("[TB] single bit in slice 0");
      applyStimulus(1'b0, refIn, "ref");
      collectOutputs(refOut, "ref", 0, 3);
      checkIdle("ref");

      $display("[TB] backpressure and blocked input during emit");
      applyStimulus(1'b0, refIn, "bp");
      collectOutputs(refOut, "bp", 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         outReady = 1'b0;
         inValid  = 1'b1;
         inData   = 25'h1FFFFFF;
         checkOutput($sformatf("bp hold data c%0d", k), {7'd0, outData}, {7'd0, refOut[1]});
         checkOutput($sformatf("bp hold last c%0d", k), {31'd0, outLast}, 32'd0);
         checkOutput($sformatf("bp hold in_ready c%0d", k), {31'd0, inReady}, 32'd0);
      end
      collectOutputs(refOut, "bp", 1, 3);
      @(negedge clk);
      checkOutput("bp after in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("bp after busy", {31'd0, busy}, 32'd0);
      inValid = 1'b0;
      inData  = '0;

      $display("[TB] wrap from slice 3 into slice 0");
      applyStimulus(1'b0, wrapIn, "wrap");
      collectOutputs(wrapOut, "wrap", 0, 3);
      checkIdle("wrap");

      $display("[TB] parity-only mode");
      applyStimulus(1'b1, parIn, "par");
      collectOutputs(parOut, "par", 0, 3);
      checkIdle("par");

      $display("[TB] reset during emit");
      applyStimulus(1'b0, refIn, "rst");
      collectOutputs(refOut, "rst", 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("rst busy", {31'd0, busy}, 32'd0);
      checkOutput("rst out_data", {7'd0, outData}, 32'd0);
      checkOutput("rst out_last", {31'd0, outLast}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst release in_ready", {31'd0, inReady}, 32'd1);
      applyStimulus(1'b0, refIn, "reload");
      collectOutputs(refOut, "reload", 0, 3);
      checkIdle("reload");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
